// File: rtl/ifs_pkg.sv
// Shared types and default timing constants for the CAN interframe-space controller.
package ifs_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME   = 2'd0,
    INTERMISSION = 2'd1,
    SUSPEND      = 2'd2,
    BUS_IDLE     = 2'd3
  } ifsState_e;

  localparam int DEF_INTERMISSION_LEN = 3;
  localparam int DEF_SUSPEND_LEN      = 8;
  localparam int DEF_MAX_OVERLOAD     = 2;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ifs_bit_counter.sv
// Sample-enabled recessive-bit counter shared by intermission and suspend tracking.
module ifs_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             increment,
  input  logic [WIDTH-1:0] termValue,
  output logic [WIDTH-1:0] count,
  output logic             atTerm
);

  // Counter register: clear beats load beats increment, all gated by the sample strobe.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count <= {WIDTH{1'b0}};
    end else if (enable) begin
      if (clear) begin
        count <= {WIDTH{1'b0}};
      end else if (load) begin
        count <= loadValue;
      end else if (increment) begin
        count <= count + WIDTH'(1);
      end
    end
  end

  assign atTerm = (count == termValue);

endmodule

// File: rtl/ifs_controller.sv
// Interframe-space FSM: intermission, suspend transmission, bus idle, overload limiting.
module ifs_controller
  import ifs_pkg::*;
#(
  parameter int INTERMISSION_LEN = DEF_INTERMISSION_LEN,
  parameter int SUSPEND_LEN      = DEF_SUSPEND_LEN,
  parameter int MAX_OVERLOAD     = DEF_MAX_OVERLOAD
) (
  input  logic clock,
  input  logic resetN,
  input  logic samplePoint,
  input  logic canRX,
  input  logic frameReady,
  input  logic endOverload,
  input  logic errorPassive,
  input  logic wasTransmitter,
  output logic isOverload,
  output logic overloadLimit,
  output logic isStart,
  output logic busIdle,
  output logic suspendActive,
  output logic txAllowed
);

  localparam int CNT_W = $clog2(maxOf(INTERMISSION_LEN, SUSPEND_LEN) + 1);
  localparam int OVL_W = $clog2(MAX_OVERLOAD + 1);
  localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTERMISSION_LEN - 1);
  localparam logic [CNT_W-1:0] SUSP_LAST  = CNT_W'(SUSPEND_LEN - 1);
  localparam logic [OVL_W-1:0] OVL_MAX    = OVL_W'(MAX_OVERLOAD);

  ifsState_e        state, nextState;
  logic [OVL_W-1:0] ovlCnt, nextOvlCnt;
  logic [CNT_W-1:0] bitCnt, cntLoadValue, termValue;
  logic             cntClear, cntLoad, cntInc, cntAtTerm;
  logic             forcedZero, lastBit;
  logic             overloadReq, limitReq, startReq;

  assign termValue = (state == SUSPEND) ? SUSP_LAST : INTER_LAST;

  ifs_bit_counter #(.WIDTH(CNT_W)) bitCounter (
    .clock     (clock),
    .resetN    (resetN),
    .enable    (samplePoint),
    .clear     (cntClear),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .increment (cntInc),
    .termValue (termValue),
    .count     (bitCnt),
    .atTerm    (cntAtTerm)
  );

  // Next-state, counter control and pulse requests for the current sample.
  always_comb begin
    nextState    = state;
    nextOvlCnt   = ovlCnt;
    cntClear     = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = {CNT_W{1'b0}};
    cntInc       = 1'b0;
    overloadReq  = 1'b0;
    limitReq     = 1'b0;
    startReq     = 1'b0;
    // After an overload delimiter, or out of WAIT_FRAME, this sample is intermission bit 0.
    forcedZero   = endOverload || (state == WAIT_FRAME);
    lastBit      = !forcedZero && (state == INTERMISSION) && cntAtTerm;
    if (!samplePoint) begin
      nextState = state;
    end else if (!frameReady) begin
      nextState = WAIT_FRAME;
      cntClear  = 1'b1;
    end else if (forcedZero || (state == INTERMISSION)) begin
      if (canRX) begin
        if (lastBit) begin
          cntClear  = 1'b1;
          nextState = (errorPassive && wasTransmitter) ? SUSPEND : BUS_IDLE;
        end else begin
          nextState    = INTERMISSION;
          cntLoad      = 1'b1;
          cntLoadValue = forcedZero ? CNT_W'(1) : bitCnt + CNT_W'(1);
        end
      end else begin
        cntClear  = 1'b1;
        nextState = WAIT_FRAME;
        if (lastBit) begin
          startReq   = 1'b1;
          nextOvlCnt = {OVL_W{1'b0}};
        end else if (ovlCnt < OVL_MAX) begin
          overloadReq = 1'b1;
          nextOvlCnt  = ovlCnt + OVL_W'(1);
        end else begin
          limitReq = 1'b1;
        end
      end
    end else begin
      case (state)
        SUSPEND: begin
          if (canRX) begin
            if (cntAtTerm) begin
              cntClear  = 1'b1;
              nextState = BUS_IDLE;
            end else begin
              cntInc = 1'b1;
            end
          end else begin
            startReq   = 1'b1;
            nextOvlCnt = {OVL_W{1'b0}};
            cntClear   = 1'b1;
            nextState  = WAIT_FRAME;
          end
        end
        BUS_IDLE: begin
          if (!canRX) begin
            startReq  = 1'b1;
            cntClear  = 1'b1;
            nextState = WAIT_FRAME;
          end else begin
            nextState = BUS_IDLE;
          end
        end
        default: begin
          cntClear  = 1'b1;
          nextState = BUS_IDLE;
        end
      endcase
    end
  end

  // State, overload count and registered outputs; a pulse high last clock is forced low.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= BUS_IDLE;
      ovlCnt        <= {OVL_W{1'b0}};
      busIdle       <= 1'b1;
      suspendActive <= 1'b0;
      isOverload    <= 1'b0;
      overloadLimit <= 1'b0;
      isStart       <= 1'b0;
    end else begin
      state         <= nextState;
      ovlCnt        <= (nextState == BUS_IDLE) ? {OVL_W{1'b0}} : nextOvlCnt;
      busIdle       <= (nextState == BUS_IDLE);
      suspendActive <= (nextState == SUSPEND);
      isOverload    <= overloadReq && !isOverload;
      overloadLimit <= limitReq && !overloadLimit;
      isStart       <= startReq && !isStart;
    end
  end

  assign txAllowed = busIdle;

endmodule

// File: tb/tb_ifs_controller.sv
// Self-checking bench for ifs_controller with default lengths (3 / 8 / 2).
module tb_ifs_controller;

  logic clock = 1'b0;
  logic resetN, samplePoint, canRX, frameReady, endOverload, errorPassive, wasTransmitter;
  logic isOverload, overloadLimit, isStart, busIdle, suspendActive, txAllowed;
  logic [4:0] outs;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] OVL  = 5'b10000;
  localparam logic [4:0] LIM  = 5'b01000;
  localparam logic [4:0] STA  = 5'b00100;
  localparam logic [4:0] IDLE = 5'b00010;
  localparam logic [4:0] SUSP = 5'b00001;

  typedef struct {
    logic       fr;
    logic       eo;
    logic       ep;
    logic       wt;
    logic       rx;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int checks   = 0;
  int failures = 0;

  ifs_controller dut (
    .clock          (clock),
    .resetN         (resetN),
    .samplePoint    (samplePoint),
    .canRX          (canRX),
    .frameReady     (frameReady),
    .endOverload    (endOverload),
    .errorPassive   (errorPassive),
    .wasTransmitter (wasTransmitter),
    .isOverload     (isOverload),
    .overloadLimit  (overloadLimit),
    .isStart        (isStart),
    .busIdle        (busIdle),
    .suspendActive  (suspendActive),
    .txAllowed      (txAllowed)
  );

  always #5 clock = ~clock;

  assign outs = {isOverload, overloadLimit, isStart, busIdle, suspendActive};

  function automatic void addVec(input logic fr, input logic eo, input logic ep,
                                 input logic wt, input logic rx, input logic [4:0] e);
    vec_t v;
    v = '{fr, eo, ep, wt, rx, e};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={ovl,lim,start,idle,susp}=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One sample clock followed by one quiet clock; expected value goes through the scoreboard.
  task automatic applySample(input int idx, input vec_t v);
    logic [4:0] e;
    @(negedge clock);
    frameReady = v.fr; endOverload = v.eo; errorPassive = v.ep;
    wasTransmitter = v.wt; canRX = v.rx; samplePoint = 1'b1;
    sb.push_back(v.exp);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d", idx), outs, e);
    check($sformatf("vec%0d_txAllowed", idx), {4'b0000, txAllowed}, {4'b0000, e[1]});
    @(negedge clock);
    samplePoint = 1'b0; endOverload = 1'b0;
    @(posedge clock);
    #1;
    check($sformatf("vec%0d_quiet", idx), outs, e & 5'b00011);
  endtask

  initial begin
    int startCount;
    int repeats;
    logic [4:0] prev;

    resetN = 1'b0; samplePoint = 1'b0; canRX = 1'b1; frameReady = 1'b0;
    endOverload = 1'b0; errorPassive = 1'b0; wasTransmitter = 1'b0;

    // fr eo ep wt rx expected
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IDLE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STA);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LIM);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STA);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IDLE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STA);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OVL);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LIM);
    // frameReady low overrides a dominant bit mid-intermission
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STA);
    // full suspend: 3 intermission + 8 suspend samples
    addVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NONE);
    for (int k = 1; k <= 11; k++)
      addVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, (k < 3) ? NONE : ((k < 11) ? SUSP : IDLE));
    // suspend aborted by a dominant bit at the 5th suspend sample
    addVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NONE);
    for (int k = 1; k <= 7; k++)
      addVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, (k < 3) ? NONE : SUSP);
    addVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, STA);
    // settle into BUS_IDLE for the hand-written sequences
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IDLE);

    #12;
    check("reset_state", outs, IDLE);
    check("reset_txAllowed", {4'b0000, txAllowed}, 5'b00001);
    @(negedge clock);
    resetN = 1'b1;

    foreach (vecs[i]) applySample(i, vecs[i]);

    // samplePoint low: canRX activity must not move anything
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      canRX = i[0];
      samplePoint = 1'b0;
      @(posedge clock);
      #1;
      check($sformatf("hold%0d", i), outs, IDLE);
    end

    // samplePoint held high with dominant bus in BUS_IDLE
    startCount = 0;
    repeats = 0;
    prev = outs;
    @(negedge clock);
    frameReady = 1'b1; canRX = 1'b0; samplePoint = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (isStart) startCount++;
      if ((prev[4:2] & outs[4:2]) != 3'b000) repeats++;
      prev = outs;
      if (i == 2) begin
        @(negedge clock);
        samplePoint = 1'b0;
      end
    end
    checkInt("held_isStart_count", startCount, 1);
    checkInt("held_pulse_repeats", repeats, 0);
    check("held_left_idle", {3'b000, busIdle, suspendActive}, NONE);

    // asynchronous reset in the middle of SUSPEND
    applySample(100, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NONE});
    applySample(101, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, NONE});
    applySample(102, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, NONE});
    applySample(103, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, SUSP});
    applySample(104, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, SUSP});
    @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset_mid_suspend", outs, IDLE);
    check("async_reset_txAllowed", {4'b0000, txAllowed}, 5'b00001);
    @(negedge clock);
    resetN = 1'b1;
    applySample(105, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STA});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifs_controller.md
# ifs_controller

Parametrised interframe-space controller for the CAN frame path. It tracks intermission, error-passive suspend transmission and bus idle between frames, and flags overload conditions and start-of-frame. It also limits consecutive overload frames and reports when the bus may be used for transmission. It sits between the bit-timing block, which supplies `samplePoint`, and the frame receiver/overload generator, which consume `isStart` and `isOverload`.

## Interface
- `INTERMISSION_LEN`, 3: intermission length in bits, ≥2.
- `SUSPEND_LEN`, 8: suspend-transmission length in bits, ≥1.
- `MAX_OVERLOAD`, 2: maximum consecutive overload frames requested, ≥1.
- `clock` in 1: system clock.
- `resetN` in 1: reset, asynchronous assert, active-low.
- `samplePoint` in 1: one-clock sample strobe. All decisions happen only on `clock` edges where this is 1.
- `canRX` in 1: sampled bus level. 1 is recessive.
- `frameReady` in 1: 1 when the preceding frame (EOF) has completed.
- `endOverload` in 1: 1 on the sample after an overload frame's delimiter.
- `errorPassive` in 1: node is error-passive.
- `wasTransmitter` in 1: node transmitted the preceding frame.
- `isOverload` out 1: one-clock pulse requesting an overload frame.
- `overloadLimit` out 1: one-clock pulse when an overload condition is seen with the limit already reached.
- `isStart` out 1: one-clock pulse marking the start-of-frame sample.
- `busIdle` out 1: level, 1 while in BUS_IDLE.
- `suspendActive` out 1: level, 1 while in SUSPEND.
- `txAllowed` out 1: level, equal to `busIdle`.

## Operation
States are WAIT_FRAME, INTERMISSION, SUSPEND and BUS_IDLE. `bitCnt` counts recessive bits in the current state. `ovlCnt` counts consecutive overloads and saturates at `MAX_OVERLOAD`.

Priority on each sampled edge, highest first:
1. `frameReady`=0: go to WAIT_FRAME with `bitCnt`=0. No pulses.
2. `endOverload`=1: evaluate `canRX` as intermission bit 0, using the INTERMISSION rule below with `bitCnt` forced to 0.
3. Otherwise, apply the per-state rule below.

WAIT_FRAME
- With `frameReady`=1, treat this sample as intermission bit 0 and apply the INTERMISSION rule.

INTERMISSION
- Recessive, `bitCnt` < `INTERMISSION_LEN`-1: increment `bitCnt`.
- Recessive on the last bit: `bitCnt`=0. Go to SUSPEND if `errorPassive`&`wasTransmitter` (values sampled on this edge), otherwise go to BUS_IDLE.
- Dominant on the last bit: pulse `isStart`, clear `ovlCnt`, go to WAIT_FRAME.
- Dominant before the last bit is an overload condition.
  - If `ovlCnt` < `MAX_OVERLOAD`: pulse `isOverload` and increment `ovlCnt`.
  - Otherwise: pulse `overloadLimit` only.
  - In both cases go to WAIT_FRAME with `bitCnt`=0.

SUSPEND
- Recessive: increment `bitCnt`. At `SUSPEND_LEN` recessive bits, go to BUS_IDLE.
- Dominant: pulse `isStart`, clear `ovlCnt`, go to WAIT_FRAME. This is another node's SOF and aborts the suspend.

BUS_IDLE
- Entering this state clears `ovlCnt`.
- Recessive: stay.
- Dominant: pulse `isStart`, go to WAIT_FRAME.

General rules
- `isOverload`, `overloadLimit` and `isStart` are mutually exclusive.
- No pulse ever lasts longer than one clock, even when `samplePoint` is held high.

## Timing
- Reset (asynchronous, `resetN`=0):
  - State goes to BUS_IDLE; `bitCnt`=0; `ovlCnt`=0.
  - Outputs: `busIdle`=1, `txAllowed`=1, all others 0.
- Reset applies immediately mid-frame or mid-suspend.
- All outputs are registered. Pulses assert on the clock edge where `samplePoint`=1 and clear on the next edge.
- Latency from the deciding sample to the output is 0 extra cycles: the output is visible after that same edge.
- With `samplePoint`=0, state, counters and levels hold and no pulses are generated, whatever `canRX` does.
- Counter width is `$clog2(max(INTERMISSION_LEN, SUSPEND_LEN)+1)`. Overflow is unreachable by construction.
- `ovlCnt` width is `$clog2(MAX_OVERLOAD+1)`. It saturates and does not wrap.

## Structure
- `ifs_pkg` holds the state enum encoding and the default length constants.
- One sub-module, `ifs_bit_counter`: a loadable, clearable, sample-enabled up-counter with a terminal-count compare input. It is instantiated once and shared by INTERMISSION and SUSPEND.
- The top-level FSM and `ovlCnt` live in `ifs_controller`.

## Test plan
- `frameReady` rises, then 3 recessive samples: `busIdle`=1 after the 3rd sample. A subsequent dominant sample gives an `isStart` pulse and `busIdle`=0.
- Dominant at intermission bit 0: `isOverload` pulse, `ovlCnt`=1. Then `endOverload`+dominant: second `isOverload`. Then a third `endOverload`+dominant: `overloadLimit` pulse and no `isOverload`.
- Recessive, recessive, then dominant at bit 2: `isStart` pulse, no overload, `ovlCnt` cleared.
- `errorPassive`=`wasTransmitter`=1 with 11 recessive samples: `suspendActive` for samples 4–11, `busIdle` after sample 11. Repeat with dominant at the 5th suspend sample: `isStart` pulse and `suspendActive`=0.
- `resetN` low during SUSPEND between clock edges: `busIdle`=1 and `suspendActive`=0 immediately, with no clock required.
- `samplePoint` held 0 for 20 clocks while `canRX` toggles: no output change. `samplePoint` held 1 for 3 clocks with dominant in BUS_IDLE: exactly one `isStart` pulse.
